ctrl_lectura: RTL and testbench

CTRL_LECTURA -- requirements
Module: ctrl_lectura

---
 rtl/ctrl_lectura_pkg.sv | 18 +
 rtl/fifo_cmd.sv | 65 ++++++
 rtl/ctrl_lectura.sv | 119 +++++++++++
 tb/tb_ctrl_lectura.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_lectura_pkg.sv
// Shared constants for the read controller: code width, FSM state encoding
// and the code value consumed by the downstream flag register.
package ctrl_lectura_pkg;

  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] cod_t;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    LEER   = 2'd1,
    ESPERA = 2'd2
  } estado_t;

  // Code the flag register reacts to
  localparam cod_t COD_BANDERA = 3'd1;

endpackage

// File: rtl/fifo_cmd.sv
// Command FIFO with wrap-around pointers and an occupancy count.
// Ports:
//   clk   - clock, rising edge
//   EN    - asynchronous active-low reset
//   push  - write din this edge (caller guarantees room, or a same-edge pop)
//   pop   - advance the read pointer this edge (caller guarantees non-empty)
//   din   - data in
//   dout  - head entry, valid while vacio=0
//   lleno - FIFO holds DEPTH entries
//   vacio - FIFO holds no entries
module fifo_cmd #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             EN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             lleno,
  output logic             vacio
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage is not reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign dout  = mem[rd_ptr];
  assign lleno = (count == CNT_W'(DEPTH));
  assign vacio = (count == '0);

endmodule

// File: rtl/ctrl_lectura.sv
// Read controller: queues 3-bit commands and issues them one at a time as
// one-cycle read strobes, with HOLD idle cycles after each read.
// Ports:
//   clk      - clock, rising edge
//   EN       - asynchronous active-low reset
//   nuevo    - one-cycle command strobe
//   cod      - command code, sampled with nuevo
//   leer     - one-cycle read strobe
//   dato     - code delivered with leer; holds its value otherwise
//   ocupado  - FSM not idle or commands pending
//   lleno    - command FIFO full
//   desborde - sticky: a command was dropped
module ctrl_lectura
  import ctrl_lectura_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 3
) (
  input  logic              clk,
  input  logic              EN,
  input  logic              nuevo,
  input  logic [CODE_W-1:0] cod,
  output logic              leer,
  output logic [CODE_W-1:0] dato,
  output logic              ocupado,
  output logic              lleno,
  output logic              desborde
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned HOLD_M1 = (HOLD > 0) ? HOLD - 1 : 0;

  estado_t           state;
  estado_t           state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              leer_n;
  cod_t              dato_n;
  logic              desborde_n;
  logic              push;
  logic              pop;
  logic              vacio;
  cod_t              fifo_dout;

  // A pop on the same edge frees a slot, so a push into a full FIFO is kept
  assign push       = nuevo && (!lleno || pop);
  assign desborde_n = desborde || (nuevo && lleno && !pop);

  fifo_cmd #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .EN    (EN),
    .push  (push),
    .pop   (pop),
    .din   (cod),
    .dout  (fifo_dout),
    .lleno (lleno),
    .vacio (vacio)
  );

  // State, counter and output registers
  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      state    <= REPOSO;
      cnt      <= '0;
      leer     <= 1'b0;
      dato     <= '0;
      desborde <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      leer     <= leer_n;
      dato     <= dato_n;
      desborde <= desborde_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    leer_n  = 1'b0;
    dato_n  = dato;
    pop     = 1'b0;
    case (state)
      REPOSO: begin
        if (!vacio) begin
          pop     = 1'b1;
          dato_n  = fifo_dout;
          leer_n  = 1'b1;
          state_n = LEER;
        end
      end
      LEER: begin
        if (HOLD > 0) begin
          state_n = ESPERA;
          cnt_n   = CNT_W'(HOLD_M1);
        end else begin
          state_n = REPOSO;
        end
      end
      ESPERA: begin
        if (cnt == '0) begin
          state_n = REPOSO;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = REPOSO;
      end
    endcase
  end

  assign ocupado = (state != REPOSO) || !vacio;

endmodule

// File: tb/tb_ctrl_lectura.sv
// Directed bench for ctrl_lectura: a DEPTH=4/HOLD=3 instance and a HOLD=0
// instance sharing clock and reset; leer pulses are logged with cycle stamps.
module tb_ctrl_lectura;
  import ctrl_lectura_pkg::*;

  logic              clk;
  logic              EN;
  logic              nuevo;
  logic              nuevo0;
  logic [CODE_W-1:0] cod;
  logic [CODE_W-1:0] cod0;
  logic [CODE_W-1:0] dato;
  logic [CODE_W-1:0] dato0;
  logic              leer;
  logic              leer0;
  logic              ocupado;
  logic              ocupado0;
  logic              lleno;
  logic              lleno0;
  logic              desborde;
  logic              desborde0;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;
  int q_cod[$];
  int q_cyc[$];
  int q0_cod[$];
  int q0_cyc[$];

  ctrl_lectura #(.DEPTH(4), .HOLD(3)) dut (
    .clk      (clk),
    .EN       (EN),
    .nuevo    (nuevo),
    .cod      (cod),
    .leer     (leer),
    .dato     (dato),
    .ocupado  (ocupado),
    .lleno    (lleno),
    .desborde (desborde)
  );

  ctrl_lectura #(.DEPTH(4), .HOLD(0)) dut0 (
    .clk      (clk),
    .EN       (EN),
    .nuevo    (nuevo0),
    .cod      (cod0),
    .leer     (leer0),
    .dato     (dato0),
    .ocupado  (ocupado0),
    .lleno    (lleno0),
    .desborde (desborde0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every read strobe with its cycle number
  always @(negedge clk) begin
    if (leer === 1'b1) begin
      q_cod.push_back(int'(dato));
      q_cyc.push_back(cyc);
    end
    if (leer0 === 1'b1) begin
      q0_cod.push_back(int'(dato0));
      q0_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CODE_W-1:0] c);
    nuevo = 1'b1;
    cod   = c;
    step();
    nuevo = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int exp_cod[6], input int n, input int gap);
    chk({tag, "_count"}, 32'(q_cod.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_code"}, 32'(q_cod[i]), 32'(exp_cod[i]));
      if (i > 0) chk({tag, "_gap"}, 32'(q_cyc[i] - q_cyc[i-1]), 32'(gap));
    end
  endtask

  initial begin
    EN     = 1'b0;
    nuevo  = 1'b0;
    nuevo0 = 1'b0;
    cod    = '0;
    cod0   = '0;
    #2;
    chk("rst_leer", 32'(leer), 32'd0);
    chk("rst_dato", 32'(dato), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_lleno", 32'(lleno), 32'd0);
    chk("rst_desborde", 32'(desborde), 32'd0);
    step(2);
    EN = 1'b1;
    step();
    chk("idle_ocupado", 32'(ocupado), 32'd0);

    // Single command: leer two cycles after the nuevo cycle
    q_cod.delete(); q_cyc.delete();
    push(COD_BANDERA);
    chk("single_ocupado", 32'(ocupado), 32'd1);
    chk("single_leer_early", 32'(leer), 32'd0);
    step();
    chk("single_leer", 32'(leer), 32'd1);
    chk("single_dato", 32'(dato), 32'(COD_BANDERA));
    step();
    chk("single_leer_one_cycle", 32'(leer), 32'd0);
    chk("single_dato_hold", 32'(dato), 32'(COD_BANDERA));
    step(2);
    chk("single_busy_hold", 32'(ocupado), 32'd1);
    step();
    chk("single_idle", 32'(ocupado), 32'd0);

    // Burst of four: spaced HOLD+2 = 5 cycles
    q_cod.delete(); q_cyc.delete();
    push(3'd1); push(3'd2); push(3'd3); push(3'd4);
    step(25);
    chk_log("burst", '{1, 2, 3, 4, 0, 0}, 4, 5);
    chk("burst_desborde", 32'(desborde), 32'd0);

    // Overflow: 7 keeps the FSM busy, then 1..6; 5 hits a full FIFO with no pop
    q_cod.delete(); q_cyc.delete();
    push(3'd7); push(3'd1); push(3'd2); push(3'd3); push(3'd4);
    chk("ovf_lleno", 32'(lleno), 32'd1);
    chk("ovf_no_drop_yet", 32'(desborde), 32'd0);
    push(3'd5);
    chk("ovf_desborde", 32'(desborde), 32'd1);
    push(3'd6);
    chk("ovf_lleno_after_pop_push", 32'(lleno), 32'd1);
    chk("ovf_leer", 32'(leer), 32'd1);
    chk("ovf_dato", 32'(dato), 32'd1);
    step(30);
    chk_log("ovf", '{7, 1, 2, 3, 4, 6}, 6, 5);
    chk("ovf_sticky", 32'(desborde), 32'd1);
    EN = 1'b0;
    #1;
    chk("ovf_rst_clears", 32'(desborde), 32'd0);
    step();
    EN = 1'b1;
    step();

    // Full FIFO with push coinciding with the REPOSO->LEER pop
    q_cod.delete(); q_cyc.delete();
    push(3'd7); push(3'd1); push(3'd2); push(3'd3); push(3'd4);
    step();
    chk("full_lleno", 32'(lleno), 32'd1);
    chk("full_leer_idle", 32'(leer), 32'd0);
    push(3'd5);
    chk("full_pp_lleno", 32'(lleno), 32'd1);
    chk("full_pp_desborde", 32'(desborde), 32'd0);
    chk("full_pp_dato", 32'(dato), 32'd1);
    step(30);
    chk_log("full", '{7, 1, 2, 3, 4, 5}, 6, 5);
    chk("full_desborde_end", 32'(desborde), 32'd0);

    // Reset during ESPERA with two entries queued
    q_cod.delete(); q_cyc.delete();
    push(3'd7); push(3'd1); push(3'd2);
    chk("mid_ocupado", 32'(ocupado), 32'd1);
    chk("mid_dato", 32'(dato), 32'd7);
    #2;
    EN = 1'b0;
    #1;
    chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
    chk("mid_rst_dato", 32'(dato), 32'd0);
    chk("mid_rst_lleno", 32'(lleno), 32'd0);
    step(2);
    EN = 1'b1;
    q_cod.delete(); q_cyc.delete();
    step(15);
    chk("mid_no_leer", 32'(q_cod.size()), 32'd0);
    chk("mid_idle", 32'(ocupado), 32'd0);
    push(3'd3);
    step();
    chk("mid_new_leer", 32'(leer), 32'd1);
    chk("mid_new_dato", 32'(dato), 32'd3);
    step(10);

    // HOLD=0 instance: three queued codes, pulses 2 cycles apart
    q0_cod.delete(); q0_cyc.delete();
    nuevo0 = 1'b1;
    cod0 = 3'd3; step();
    cod0 = 3'd5; step();
    cod0 = 3'd6; step();
    nuevo0 = 1'b0;
    step(10);
    chk("h0_count", 32'(q0_cod.size()), 32'd3);
    chk("h0_code0", 32'(q0_cod[0]), 32'd3);
    chk("h0_code1", 32'(q0_cod[1]), 32'd5);
    chk("h0_code2", 32'(q0_cod[2]), 32'd6);
    chk("h0_gap1", 32'(q0_cyc[1] - q0_cyc[0]), 32'd2);
    chk("h0_gap2", 32'(q0_cyc[2] - q0_cyc[1]), 32'd2);
    chk("h0_idle", 32'(ocupado0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
